// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice.
//   XLEN / ILEN    : address and instruction widths
//   fetch_state_t  : controller FSM states
//   fetch_entry_t  : one fetch-buffer entry {pc, instr, fault}
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: a DEPTH-entry FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, din      : enqueue request and entry
//   pop            : dequeue request (ignored when empty)
//   flush          : discard all entries; overrides push and pop
//   dout           : head entry (only meaningful when !empty)
//   count          : number of stored entries
//   full, empty    : occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t     mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             popEff;
  logic             pushEff;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign popEff  = pop && !empty;
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign pushEff = push && (!full || popEff);
  assign dout    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pushEff) wptr <= wptr + 1'b1;
      if (popEff)  rptr <= rptr + 1'b1;
      case ({pushEff, popEff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the empty flag hides stale contents.
  always_ff @(posedge clk) begin
    if (pushEff && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a PC through a combinational
// instruction memory and queues {pc, instr, fault} entries for the consumer.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   fetch_en                    : fetching permitted
//   imem_addr / imem_instr      : combinational instruction memory interface
//   redirect_valid, redirect_pc : PC change request (top priority, flushes buffer)
//   out_valid / out_ready       : handshake for the buffer head
//   out_instr, out_pc, out_fault: head entry contents (zero when no entry)
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_BYTES = 16384,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        out_fault
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd4;

  fetch_state_t   state;
  fetch_state_t   stateNext;
  logic [63:0]    pc;
  logic           doFetch;
  logic           fetchFault;
  logic           popReq;
  fetch_entry_t   pushEntry;
  fetch_entry_t   head;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  assign imem_addr  = pc;
  assign fetchFault = (pc[1:0] != 2'b00) || (pc > LAST_ADDR);
  assign out_valid  = !empty;
  assign popReq     = out_valid && out_ready;

  assign pushEntry.pc    = pc;
  assign pushEntry.instr = fetchFault ? '0 : imem_instr;
  assign pushEntry.fault = fetchFault;

  // Gate the head so the outputs read zero whenever the buffer is empty.
  assign out_pc    = empty ? '0 : head.pc;
  assign out_instr = empty ? '0 : head.instr;
  assign out_fault = empty ? 1'b0 : head.fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= stateNext;
      if (redirect_valid)             pc <= redirect_pc;
      else if (doFetch && !fetchFault) pc <= pc + 64'd4;
    end
  end

  always_comb begin
    stateNext = state;
    doFetch   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en) stateNext = RUN;
      end
      RUN: begin
        if (!fetch_en) begin
          stateNext = IDLE;
        end else if ((count < CW'(DEPTH)) || (full && popReq)) begin
          doFetch = 1'b1;
          if (fetchFault) stateNext = FAULT;
        end
      end
      FAULT: begin
        stateNext = FAULT;
      end
      default: stateNext = IDLE;
    endcase
    // A redirect suppresses this cycle's fetch and is the only way out of FAULT.
    if (redirect_valid) begin
      doFetch   = 1'b0;
      stateNext = fetch_en ? RUN : IDLE;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (doFetch),
    .pop   (popReq),
    .flush (redirect_valid),
    .din   (pushEntry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter MEM_BYTES, default 16384, meaning the instruction memory size in bytes.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the fetch-buffer entry count (power of two, >=2).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port fetch_en  input  1  fetch permitted.
REQ-007 The block SHALL have port imem_addr  output  64  byte address to the combinational instruction memory.
REQ-008 The block SHALL have port imem_instr  input  32  little-endian instruction word returned in the same cycle.
REQ-009 The block SHALL have port redirect_valid  input  1  a PC change (branch/trap) is requested.
REQ-010 The block SHALL have port redirect_pc  input  64  target of the redirect.
REQ-011 The block SHALL have port out_valid  output  1  buffer head holds a fetched entry.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts the head.
REQ-013 The block SHALL have port out_instr  output  32  head instruction.
REQ-014 The block SHALL have port out_pc  output  64  head PC.
REQ-015 The block SHALL have port out_fault  output  1  head is a fetch fault (misaligned or out-of-range); out_instr is 32'h0 in that case.

Function
REQ-016 imem_addr SHALL equal the internal pc register at all times (combinational).
REQ-017 FSM states SHALL be IDLE, RUN and FAULT: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; RUN->FAULT on a faulting enqueue; FAULT->RUN (or IDLE if fetch_en=0) only on redirect_valid.
REQ-018 A fetch SHALL occur in RUN when the buffer can accept one: count<DEPTH, or count==DEPTH with a pop in the same cycle.
REQ-019 On a fetch, {pc, imem_instr, fault=0} SHALL be enqueued and pc SHALL advance by 4 (modulo 2^64), giving fetch-to-out_valid latency of 1 cycle.
REQ-020 A fetch SHALL be faulting when pc[1:0]!=0 or pc>MEM_BYTES-4; in that case it SHALL enqueue {pc, 32'h0, fault=1}, leave pc unchanged and enter FAULT.
REQ-021 A pop SHALL occur when out_valid && out_ready; entries SHALL leave in FIFO order.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push when full without a pop SHALL not occur.
REQ-023 redirect_valid SHALL have top priority: the buffer is flushed (count=0), pc<=redirect_pc, no enqueue occurs that cycle, and any same-cycle pop is discarded with the flush.
REQ-024 The first entry after a redirect SHALL appear on out_valid 2 cycles after the redirect cycle, if fetch_en=1 and the target is valid.
REQ-025 With fetch_en=0, buffered entries SHALL remain drainable and no new fetch SHALL occur.
REQ-026 In FAULT, no fetch SHALL occur, and the fault entry SHALL remain at the head until popped or flushed.

Reset
REQ-027 While rst_n=0, the block SHALL hold pc=RESET_PC, state=IDLE, count=0, buffer pointers=0, out_valid=0, out_instr=0, out_pc=0 and out_fault=0, asynchronously and irrespective of clk.
REQ-028 Assertion of rst_n mid-operation SHALL discard all buffered entries immediately; the first fetch after deassertion SHALL be at RESET_PC.

Structure
REQ-029 Package fetch_pkg SHALL hold XLEN=64, ILEN=32, the fetch_state_t enum {IDLE, RUN, FAULT} and the fetch_entry_t struct {pc, instr, fault}.
REQ-030 The buffer SHALL be a sub-module fetch_fifo (DEPTH entries of fetch_entry_t, with push, pop, flush, count and full/empty), instantiated once.

Verification
REQ-031 Reset, then fetch_en=1 and out_ready=1 with memory words 0x00000013 @0 and 0x00100093 @4: the bench SHALL observe out_pc 0,4,8,... on consecutive cycles, with the first out_valid one cycle after the first fetch.
REQ-032 Hold out_ready=0 for 5 cycles: count SHALL saturate at 2, pc SHALL stop at 8, and on release 0,4,8 SHALL drain in order with no loss or duplicate.
REQ-033 Redirect to 0x100 while the buffer is full: the next cycle SHALL have out_valid=0, and the cycle after SHALL have out_pc=0x100.
REQ-034 Redirect to 0x102: the bench SHALL observe out_fault=1, out_pc=0x102 and out_instr=0, no further fetches, and recovery only after a redirect to 0x200.
REQ-035 Redirect to MEM_BYTES-4 (16380): that entry SHALL be valid with fault=0; the next entry, at 16384, SHALL carry out_fault=1.
REQ-036 Drop rst_n mid-burst between clock edges: out_valid SHALL fall immediately, and after release the first out_pc SHALL be RESET_PC.
